// File: rtl/if_fetch_unit_pkg.sv
// -----------------------------------------------------------------------------
// if_fetch_unit_pkg
// Shared definitions for the instruction-fetch stage:
//   - fetch_state_t : FETCH (may issue), WAIT (one request outstanding),
//                     DROP (outstanding request is stale, its response is dropped)
//   - XLEN_DEF, PC_STEP_DEF, RESET_PC_DEF : default parameter values
// -----------------------------------------------------------------------------
package if_fetch_unit_pkg;

   localparam int unsigned XLEN_DEF     = 32;
   localparam int unsigned PC_STEP_DEF  = 4;
   localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

   typedef enum logic [1:0] {
      ST_FETCH = 2'd0,
      ST_WAIT  = 2'd1,
      ST_DROP  = 2'd2
   } fetch_state_t;

endpackage

// File: rtl/if_out_reg.sv
// -----------------------------------------------------------------------------
// if_out_reg
// Valid/ready output register between fetch and decode, with flush.
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   i_flush     : drop the held instruction (redirect); wins over capture
//   i_capture   : load i_inst/i_pc and mark valid
//   i_inst      : instruction to capture
//   i_pc        : address of i_inst
//   i_ready     : downstream accepts the held instruction this cycle
//   o_valid     : register holds a valid instruction
//   o_inst      : held instruction
//   o_pc        : address of held instruction
// -----------------------------------------------------------------------------
module if_out_reg
   import if_fetch_unit_pkg::*;
#(
   parameter int unsigned XLEN = XLEN_DEF
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            i_flush,
   input  logic            i_capture,
   input  logic [XLEN-1:0] i_inst,
   input  logic [XLEN-1:0] i_pc,
   input  logic            i_ready,
   output logic            o_valid,
   output logic [XLEN-1:0] o_inst,
   output logic [XLEN-1:0] o_pc
);

   logic            r_valid;
   logic [XLEN-1:0] r_inst;
   logic [XLEN-1:0] r_pc;

   // Valid flag and payload; payload only moves on capture so it stays stable under stall.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid <= 1'b0;
         r_inst  <= '0;
         r_pc    <= '0;
      end else if (i_flush) begin
         r_valid <= 1'b0;
      end else if (i_capture) begin
         r_valid <= 1'b1;
         r_inst  <= i_inst;
         r_pc    <= i_pc;
      end else if (r_valid && i_ready) begin
         r_valid <= 1'b0;
      end else begin
         r_valid <= r_valid;
      end
   end

   assign o_valid = r_valid;
   assign o_inst  = r_inst;
   assign o_pc    = r_pc;

endmodule

// File: rtl/if_fetch_unit.sv
// -----------------------------------------------------------------------------
// if_fetch_unit
// Instruction-fetch stage: owns the PC, issues one request at a time to a
// variable-latency instruction memory and hands instructions to decode through
// a valid/ready output register. Redirects are accepted in any state; a
// redirect while a request is outstanding marks that request stale (DROP).
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   redirect_valid/_pc       : branch/jump/trap redirect, flushes the stage
//   imem_req/imem_addr       : one-cycle request pulse and its address
//   imem_rvalid/imem_rdata   : memory response strobe and instruction
//   id_ready                 : decode accepts the instruction this cycle
//   id_valid/id_inst/id_pc   : instruction presented to decode
//   id_pc_4                  : id_pc + PC_STEP
//   fetch_cnt                : count of id_valid && id_ready handshakes
// -----------------------------------------------------------------------------
module if_fetch_unit
   import if_fetch_unit_pkg::*;
#(
   parameter int unsigned      XLEN     = XLEN_DEF,
   parameter logic [XLEN-1:0]  RESET_PC = XLEN'(RESET_PC_DEF),
   parameter int unsigned      PC_STEP  = PC_STEP_DEF,
   parameter int unsigned      CNT_W    = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             redirect_valid,
   input  logic [XLEN-1:0]  redirect_pc,
   output logic             imem_req,
   output logic [XLEN-1:0]  imem_addr,
   input  logic             imem_rvalid,
   input  logic [XLEN-1:0]  imem_rdata,
   input  logic             id_ready,
   output logic             id_valid,
   output logic [XLEN-1:0]  id_inst,
   output logic [XLEN-1:0]  id_pc,
   output logic [XLEN-1:0]  id_pc_4,
   output logic [CNT_W-1:0] fetch_cnt
);

   fetch_state_t     r_state;
   logic [XLEN-1:0]  r_pc;
   logic [CNT_W-1:0] r_cnt;

   logic             w_issue;
   logic             w_capture;
   logic [XLEN-1:0]  w_pc_next;
   logic             w_out_valid;
   logic [XLEN-1:0]  w_out_inst;
   logic [XLEN-1:0]  w_out_pc;

   assign w_pc_next = r_pc + XLEN'(PC_STEP);

   // Issue only when the output register will be free by the time data returns.
   always_comb begin
      w_issue   = 1'b0;
      w_capture = 1'b0;
      if (!rst && (r_state == ST_FETCH) && !redirect_valid && (!w_out_valid || id_ready)) begin
         w_issue = 1'b1;
      end else begin
         w_issue = 1'b0;
      end
      if ((r_state == ST_WAIT) && imem_rvalid && !redirect_valid) begin
         w_capture = 1'b1;
      end else begin
         w_capture = 1'b0;
      end
   end

   // PC and fetch state machine.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_FETCH;
         r_pc    <= RESET_PC;
      end else begin
         case (r_state)
            ST_FETCH: begin
               if (redirect_valid) begin
                  r_pc <= redirect_pc;
               end else if (w_issue) begin
                  r_state <= ST_WAIT;
               end else begin
                  r_state <= ST_FETCH;
               end
            end
            ST_WAIT: begin
               if (imem_rvalid) begin
                  r_state <= ST_FETCH;
                  r_pc    <= redirect_valid ? redirect_pc : w_pc_next;
               end else if (redirect_valid) begin
                  r_state <= ST_DROP;
                  r_pc    <= redirect_pc;
               end else begin
                  r_state <= ST_WAIT;
               end
            end
            ST_DROP: begin
               // The stale response still has to arrive before a new request may go out.
               if (redirect_valid) begin
                  r_pc <= redirect_pc;
               end else begin
                  r_pc <= r_pc;
               end
               if (imem_rvalid) begin
                  r_state <= ST_FETCH;
               end else begin
                  r_state <= ST_DROP;
               end
            end
            default: begin
               r_state <= ST_FETCH;
            end
         endcase
      end
   end

   // Delivered-instruction counter; a handshake coinciding with a redirect still counts.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (w_out_valid && id_ready) begin
         r_cnt <= r_cnt + CNT_W'(1);
      end else begin
         r_cnt <= r_cnt;
      end
   end

   if_out_reg #(
      .XLEN (XLEN)
   ) u_out_reg (
      .clk       (clk),
      .rst       (rst),
      .i_flush   (redirect_valid),
      .i_capture (w_capture),
      .i_inst    (imem_rdata),
      .i_pc      (r_pc),
      .i_ready   (id_ready),
      .o_valid   (w_out_valid),
      .o_inst    (w_out_inst),
      .o_pc      (w_out_pc)
   );

   assign imem_req  = w_issue;
   assign imem_addr = r_pc;
   assign id_valid  = w_out_valid;
   assign id_inst   = w_out_inst;
   assign id_pc     = w_out_pc;
   assign id_pc_4   = w_out_pc + XLEN'(PC_STEP);
   assign fetch_cnt = r_cnt;

endmodule
